// File: rtl/mem_access_unit.sv
// Data-memory access unit: aligns stores, extends loads, and runs the dmem
// request/response handshake with a bounded wait and pipeline stall.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [3:0]  req_store_mask,
    input  logic        req_load,
    input  logic [2:0]  req_funct,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        misaligned,
    output logic        timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    funct_q, funct_d;
    logic          is_load_q, is_load_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          req_valid_q, req_valid_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          misaligned_q, misaligned_d;
    logic          timeout_q, timeout_d;

    logic          op_store, op_load, op_legal;
    logic [31:0]   rd_shift, rd_ext;

    // Op classification and alignment legality of the incoming request
    always_comb begin
        op_store = (req_store_mask != 4'b0000);
        op_load  = !op_store && req_load;
        op_legal = 1'b0;
        if (op_store) begin
            case (req_store_mask)
                4'b0001: op_legal = 1'b1;
                4'b0011: op_legal = !req_addr[0];
                4'b1111: op_legal = (req_addr[1:0] == 2'b00);
                default: op_legal = 1'b0;
            endcase
        end else if (op_load) begin
            case (req_funct)
                3'd0, 3'd4: op_legal = 1'b1;
                3'd1, 3'd5: op_legal = !req_addr[0];
                default:    op_legal = (req_addr[1:0] == 2'b00);
            endcase
        end
    end

    // Load data extraction; unknown funct3 codes behave as LW
    always_comb begin
        rd_shift = dmem_rdata >> {off_q, 3'b000};
        case (funct_q)
            3'd0:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd4:    rd_ext = {24'h0, rd_shift[7:0]};
            3'd1:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd5:    rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        funct_d      = funct_q;
        is_load_d    = is_load_q;
        rsp_data_d   = rsp_data_q;
        misaligned_d = 1'b0;
        timeout_d    = timeout_q;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && (op_store || op_load)) begin
                    if (op_legal) begin
                        stall      = 1'b1;
                        state_d    = REQ;
                        cnt_d      = '0;
                        addr_d     = {req_addr[31:2], 2'b00};
                        we_d       = op_store ? 4'(req_store_mask << req_addr[1:0]) : 4'b0000;
                        wdata_d    = req_wdata << {req_addr[1:0], 3'b000};
                        off_d      = req_addr[1:0];
                        funct_d    = req_funct;
                        is_load_d  = op_load;
                        rsp_data_d = '0;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                cnt_d = CW'(cnt_q + 1'b1);
                if (dmem_req_ready) begin
                    state_d = is_load_q ? WAIT : DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d    = DONE;
                    timeout_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = CW'(cnt_q + 1'b1);
                if (dmem_resp_valid) begin
                    state_d    = DONE;
                    rsp_data_d = rd_ext;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d    = DONE;
                    timeout_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_valid_d = (state_d == REQ);
        rsp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= '0;
            wdata_q      <= '0;
            off_q        <= '0;
            funct_q      <= '0;
            is_load_q    <= 1'b0;
            rsp_data_q   <= '0;
            req_valid_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            off_q        <= off_d;
            funct_q      <= funct_d;
            is_load_q    <= is_load_d;
            rsp_data_q   <= rsp_data_d;
            req_valid_q  <= req_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_wdata     = wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign misaligned     = misaligned_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected dmem
// requests and responses; responder and monitor processes pop and compare.
module tb_mem_access_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_store_mask = 4'b0;
    logic        req_load = 1'b0;
    logic [2:0]  req_funct = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        misaligned;
    logic        timeout;

    mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_store_mask(req_store_mask), .req_load(req_load),
        .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .misaligned(misaligned), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        to;
    } rsp_t;

    req_t        exp_req[$];
    rsp_t        exp_rsp[$];
    int          exp_mis = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        to_exp = 1'b0;
    logic        mem_ready_en = 1'b1;
    int          mem_delay = 1;
    logic [31:0] mem_rdata = 32'h0;
    int          resp_cnt = 0;
    req_t        er;
    rsp_t        rr;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Memory responder: accepts when enabled, checks request fields, returns load data later
    initial begin
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 32'h0;
        forever begin
            @(negedge clk);
            dmem_resp_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    dmem_resp_valid = 1'b1;
                    dmem_rdata      = mem_rdata;
                end
            end
            dmem_req_ready = mem_ready_en;
            if (dmem_req_valid && dmem_req_ready) begin
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_req: got addr %0h we %0h, no request expected", dmem_addr, dmem_we);
                end else begin
                    er = exp_req.pop_front();
                    check("req_addr", 64'(dmem_addr), 64'(er.addr));
                    check("req_we", 64'(dmem_we), 64'(er.we));
                    check("req_wdata", 64'(dmem_wdata), 64'(er.wdata));
                    if (dmem_we == 4'b0000) resp_cnt = mem_delay;
                end
            end
        end
    end

    // Response / misaligned monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got data %0h, no response expected", rsp_data);
                end else begin
                    rr = exp_rsp.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(rr.data));
                    check("rsp_timeout", 64'(timeout), 64'(rr.to));
                    check("rsp_stall", 64'(stall), 64'(0));
                end
            end
            if (misaligned) begin
                if (exp_mis == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_misaligned: got pulse, none expected");
                end else begin
                    exp_mis--;
                    check("mis_stall", 64'(stall), 64'(0));
                    check("mis_dmem_valid", 64'(dmem_req_valid), 64'(0));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] mask, input logic ld, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd, input logic legal);
        @(negedge clk);
        req_valid = 1'b1; req_store_mask = mask; req_load = ld;
        req_funct = f; req_addr = a; req_wdata = wd;
        #1 check("stall_accept", 64'(stall), 64'(legal));
        @(negedge clk);
        req_valid = 1'b0; req_store_mask = 4'b0; req_load = 1'b0;
        check("stall_next", 64'(stall), 64'(legal));
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 100);
        if (!rsp_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_wait: got no rsp_valid within %0d cycles", cyc);
        end
    endtask

    task automatic do_store(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] ea, input logic [3:0] ewe, input logic [31:0] ewd);
        req_t r;
        rsp_t s;
        int   cyc;
        r.addr = ea; r.we = ewe; r.wdata = ewd;
        s.data = 32'h0; s.to = to_exp;
        exp_req.push_back(r);
        exp_rsp.push_back(s);
        issue(mask, 1'b0, 3'd2, a, wd, 1'b1);
        wait_rsp(cyc);
        check("store_latency", 64'(cyc), 64'(1));
    endtask

    task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd,
                           input int delay, input logic [31:0] edata, input int ecyc);
        req_t r;
        rsp_t s;
        int   cyc;
        mem_rdata = rd; mem_delay = delay;
        r.addr = {a[31:2], 2'b00}; r.we = 4'b0000; r.wdata = 32'h0;
        s.data = edata; s.to = to_exp;
        exp_req.push_back(r);
        exp_rsp.push_back(s);
        issue(4'b0000, 1'b1, f, a, 32'h0, 1'b1);
        wait_rsp(cyc);
        check("load_latency", 64'(cyc), 64'(ecyc));
    endtask

    task automatic do_bad(input logic [3:0] mask, input logic ld, input logic [2:0] f, input logic [31:0] a);
        exp_mis++;
        issue(mask, ld, f, a, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("mis_pulse_seen", 64'(exp_mis), 64'(0));
    endtask

    initial begin
        int cyc;
        rsp_t s;
        req_t r;

        #1;
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_outs", 64'({dmem_req_valid, rsp_valid, misaligned, timeout, dmem_we}), 64'(0));
        check("rst_addr", 64'(dmem_addr), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stores: word, byte at top lane, half at upper lane
        do_store(4'b1111, 32'h104, 32'hDEADBEEF, 32'h104, 4'b1111, 32'hDEADBEEF);
        do_store(4'b0001, 32'h103, 32'h000000AB, 32'h100, 4'b1000, 32'hAB000000);
        do_store(4'b0011, 32'h102, 32'h00001234, 32'h100, 4'b1100, 32'h12340000);

        // Loads at 0x202 with a 3-cycle response
        do_load(3'd0, 32'h202, 32'h80FF7F00, 3, 32'hFFFFFFFF, 4);
        do_load(3'd4, 32'h202, 32'h80FF7F00, 3, 32'h000000FF, 4);
        do_load(3'd1, 32'h202, 32'h80FF7F00, 3, 32'hFFFF80FF, 4);
        do_load(3'd5, 32'h202, 32'h80FF7F00, 3, 32'h000080FF, 4);
        do_load(3'd2, 32'h200, 32'h80FF7F00, 1, 32'h80FF7F00, 2);
        do_load(3'd0, 32'h201, 32'h80FF7F00, 1, 32'h0000007F, 2);
        do_load(3'd3, 32'h204, 32'hA5A55A5A, 1, 32'hA5A55A5A, 2);

        // Illegal ops and an ignored no-op
        do_bad(4'b0000, 1'b1, 3'd1, 32'h201);
        do_bad(4'b0000, 1'b1, 3'd2, 32'h102);
        do_bad(4'b0101, 1'b0, 3'd2, 32'h100);
        do_bad(4'b0011, 1'b0, 3'd2, 32'h103);
        do_bad(4'b0000, 1'b1, 3'd7, 32'h201);
        issue(4'b0000, 1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
        repeat (2) @(negedge clk);

        // Response in the last allowed cycle completes normally
        do_load(3'd2, 32'h300, 32'h0BADCAFE, 15, 32'h0BADCAFE, TO);
        check("timeout_not_set", 64'(timeout), 64'(0));

        // Memory never ready: abort after TO cycles
        mem_ready_en = 1'b0;
        to_exp = 1'b1;
        s.data = 32'h0; s.to = 1'b1;
        exp_rsp.push_back(s);
        issue(4'b1111, 1'b0, 3'd2, 32'h300, 32'h11223344, 1'b1);
        wait_rsp(cyc);
        check("timeout_latency", 64'(cyc), 64'(TO));
        check("timeout_dmem_valid", 64'(dmem_req_valid), 64'(0));
        mem_ready_en = 1'b1;
        repeat (3) @(negedge clk);
        check("timeout_sticky", 64'(timeout), 64'(1));
        do_store(4'b1111, 32'h308, 32'h55667788, 32'h308, 4'b1111, 32'h55667788);

        // Response one cycle too late is lost to the timeout
        do_load(3'd2, 32'h310, 32'h77777777, 16, 32'h0, TO);
        repeat (3) @(negedge clk);

        // Reset during WAIT abandons the load
        mem_rdata = 32'hCAFEF00D; mem_delay = 5;
        r.addr = 32'h400; r.we = 4'b0000; r.wdata = 32'h0;
        exp_req.push_back(r);
        issue(4'b0000, 1'b1, 3'd2, 32'h400, 32'h0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stall", 64'(stall), 64'(0));
        check("arst_flags", 64'({dmem_req_valid, rsp_valid, misaligned, timeout}), 64'(0));
        check("arst_rsp_data", 64'(rsp_data), 64'(0));
        check("arst_addr", 64'(dmem_addr), 64'(0));
        to_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_load(3'd2, 32'h0, 32'h12345678, 1, 32'h12345678, 2);
        repeat (2) @(negedge clk);

        check("req_queue_drained", 64'(exp_req.size()), 64'(0));
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));
        check("mis_queue_drained", 64'(exp_mis), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
